// File: rtl/vga_pkg.sv
// Shared VGA definitions: coordinate width, 640x480@60 timing defaults,
// draw-block colour constants and a sync-level helper.
package vga_pkg;

   localparam int COORD_W = 10;

   typedef logic [COORD_W-1:0] coord_t;

   localparam int H_RES_DEF  = 640;
   localparam int H_FP_DEF   = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;
   localparam int V_RES_DEF  = 480;
   localparam int V_FP_DEF   = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;

   // 6-bit rgb as {r[1:0], g[1:0], b[1:0]}
   localparam logic [5:0] RGB_BLACK  = 6'b00_00_00;
   localparam logic [5:0] RGB_WHITE  = 6'b11_11_11;
   localparam logic [5:0] RGB_RED    = 6'b11_00_00;
   localparam logic [5:0] RGB_GREEN  = 6'b00_11_00;
   localparam logic [5:0] RGB_BLUE   = 6'b00_00_11;
   localparam logic [5:0] RGB_YELLOW = 6'b11_11_00;
   localparam logic [5:0] RGB_CYAN   = 6'b00_11_11;
   localparam logic [5:0] RGB_GREY   = 6'b01_01_01;

   function automatic logic sync_level(input logic active, input logic pol);
      return active ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with enable, terminal count,
// and active/sync window flags decoded from the value the counter moves to.
module vga_axis_cnt
   import vga_pkg::*;
#(
   parameter int TOTAL      = 800,
   parameter int ACTIVE     = 640,
   parameter int SYNC_START = 656,
   parameter int SYNC_END   = 751
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [COORD_W-1:0] cnt,
   output logic               tc,
   output logic               active_next,
   output logic               sync_next
);

   localparam logic [COORD_W-1:0] LAST    = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] ACT_END = COORD_W'(ACTIVE);
   localparam logic [COORD_W-1:0] SYNC_LO = COORD_W'(SYNC_START);
   localparam logic [COORD_W-1:0] SYNC_HI = COORD_W'(SYNC_END);

   logic [COORD_W-1:0] cnt_next;

   // Flags are decoded from cnt_next so the registers fed by them line up
   // with the count that is presented in the same cycle.
   always_comb begin
      tc       = (cnt == LAST);
      cnt_next = cnt;
      if (en) begin
         cnt_next = tc ? '0 : cnt + COORD_W'(1);
      end
      active_next = (cnt_next < ACT_END);
      sync_next   = (cnt_next >= SYNC_LO) && (cnt_next <= SYNC_HI);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= LAST;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster source: sx/sy/de, hsync/vsync, line/frame strobes, frame counter.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync one clk to match draw-block rgb.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_RES    = H_RES_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_RES    = V_RES_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_en,
   output logic [COORD_W-1:0] sx,
   output logic [COORD_W-1:0] sy,
   output logic               de,
   output logic               hsync,
   output logic               vsync,
   output logic               line_start,
   output logic               frame_start,
   output logic [7:0]         frame_cnt
);

   localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

   logic h_tc, h_active_next, h_sync_next;
   logic v_tc, v_active_next, v_sync_next;
   logic line_tick, frame_tick;
   logic hsync_q, vsync_q;

   assign line_tick  = pix_en & h_tc;
   assign frame_tick = line_tick & v_tc;

   vga_axis_cnt #(
      .TOTAL      (H_TOTAL),
      .ACTIVE     (H_RES),
      .SYNC_START (H_RES + H_FP),
      .SYNC_END   (H_RES + H_FP + H_SYNC - 1)
   ) h_axis (
      .clk         (clk),
      .rst         (rst),
      .en          (pix_en),
      .cnt         (sx),
      .tc          (h_tc),
      .active_next (h_active_next),
      .sync_next   (h_sync_next)
   );

   vga_axis_cnt #(
      .TOTAL      (V_TOTAL),
      .ACTIVE     (V_RES),
      .SYNC_START (V_RES + V_FP),
      .SYNC_END   (V_RES + V_FP + V_SYNC - 1)
   ) v_axis (
      .clk         (clk),
      .rst         (rst),
      .en          (line_tick),
      .cnt         (sy),
      .tc          (v_tc),
      .active_next (v_active_next),
      .sync_next   (v_sync_next)
   );

   // Strobes are recomputed every clk, so they fall on the first cycle
   // after a tick whatever the pix_en duty cycle is.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de          <= 1'b0;
         hsync_q     <= ~SYNC_POL;
         vsync_q     <= ~SYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= 8'hFF;
      end else begin
         de          <= h_active_next & v_active_next;
         hsync_q     <= sync_level(h_sync_next, SYNC_POL);
         vsync_q     <= sync_level(v_sync_next, SYNC_POL);
         line_start  <= line_tick;
         frame_start <= frame_tick;
         if (frame_tick) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

`ifdef VGA_SYNC_DELAY_EN
   logic hsync_d, vsync_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_d <= ~SYNC_POL;
         vsync_d <= ~SYNC_POL;
      end else begin
         hsync_d <= hsync_q;
         vsync_d <= vsync_q;
      end
   end

   assign hsync = hsync_d;
   assign vsync = vsync_d;
`else
   assign hsync = hsync_q;
   assign vsync = vsync_q;
`endif

endmodule
